case_mul_pipe_hs: RTL and testbench

//  Parametrised, pipelined integer multiplier with a valid/ready handshake on both sides.

---
 rtl/case_mul_pkg.sv | 33 +++
 rtl/case_mul_stage_reg.sv | 42 ++++
 rtl/case_mul_pipe_hs.sv | 119 +++++++++++
 tb/tb_case_mul_pipe_hs.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/case_mul_pkg.sv
// case_mul_pkg: product width, fit test and the {valid, product} stage record.
// CASE_MUL_STAGE_T(W) builds the record for a W-bit product.
`ifndef CASE_MUL_PKG_SV
`define CASE_MUL_PKG_SV

`define CASE_MUL_STAGE_T(W) struct packed { logic valid; logic [(W)-1:0] prod; }

package case_mul_pkg;

  localparam int MAXW = 128;

  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1;
  endfunction

  // p must already be extended to MAXW bits in its own signedness
  function automatic logic fits(
    input logic [MAXW-1:0] p,
    input int              dw,
    input logic            sgn
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAXW; i++) begin
      if (i >= dw && p[i] != (sgn & p[dw-1]))
        ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

`endif

// File: rtl/case_mul_stage_reg.sv
// case_mul_stage_reg: one valid/ready register slice of the product pipeline.
// Loads whenever it is empty or its content moves on downstream.
module case_mul_stage_reg
  import case_mul_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         up_valid_i,
  input  logic [W-1:0] up_data_i,
  input  logic         dn_ready_i,
  output logic         up_ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  typedef `CASE_MUL_STAGE_T(W) stage_t;

  stage_t st_q, st_d;

  assign up_ready_o = !st_q.valid || dn_ready_i;
  assign valid_o    = st_q.valid;
  assign data_o     = st_q.prod;

  always_comb begin
    st_d = st_q;
    if (up_ready_o) begin
      st_d.valid = up_valid_i;
      if (up_valid_i)
        st_d.prod = up_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      st_q <= '0;
    else
      st_q <= st_d;
  end

endmodule

// File: rtl/case_mul_pipe_hs.sv
// case_mul_pipe_hs: pipelined multiplier with valid/ready on both sides.
// Define CASE_MUL_PIPE_SAT_EN to clamp overflowing products instead of wrapping.
module case_mul_pipe_hs
  import case_mul_pkg::*;
#(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int din0_WIDTH  = 10,
  parameter int din1_WIDTH  = 6,
  parameter int dout_WIDTH  = 10,
  parameter int din0_SIGNED = 1,
  parameter int din1_SIGNED = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int   P    = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int   DW   = dout_WIDTH;
  localparam logic S0   = (din0_SIGNED != 0);
  localparam logic S1   = (din1_SIGNED != 0);
  localparam logic PSGN = S0 || S1;

  typedef `CASE_MUL_STAGE_T(P) stage_t;

  logic [NUM_STAGE:0] rdy;
  logic               vld [NUM_STAGE];
  logic [P-1:0]       prd [NUM_STAGE];

  // low P bits of a P-bit multiply are exact for any signedness mix
  logic [P-1:0] a_ext, b_ext, mul;

  assign a_ext = S0 ?
    {{(P-din0_WIDTH){din0[din0_WIDTH-1]}}, din0} :
    {{(P-din0_WIDTH){1'b0}}, din0};
  assign b_ext = S1 ?
    {{(P-din1_WIDTH){din1[din1_WIDTH-1]}}, din1} :
    {{(P-din1_WIDTH){1'b0}}, din1};
  assign mul = a_ext * b_ext;

  stage_t s0_q, s0_d;

  assign rdy[NUM_STAGE] = out_ready;
  assign rdy[0]         = !s0_q.valid || rdy[1];
  assign in_ready       = rdy[0];
  assign vld[0]         = s0_q.valid;
  assign prd[0]         = s0_q.prod;

  always_comb begin
    s0_d = s0_q;
    if (rdy[0]) begin
      s0_d.valid = in_valid;
      if (in_valid)
        s0_d.prod = mul;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)
      s0_q <= '0;
    else
      s0_q <= s0_d;
  end

  for (genvar k = 1; k < NUM_STAGE; k++) begin : g_stage
    case_mul_stage_reg #(
      .W(P)
    ) u_stage (
      .clk_i     (ap_clk),
      .rst_ni    (ap_rst_n),
      .up_valid_i(vld[k-1]),
      .up_data_i (prd[k-1]),
      .dn_ready_i(rdy[k+1]),
      .up_ready_o(rdy[k]),
      .valid_o   (vld[k]),
      .data_o    (prd[k])
    );
  end

  logic [P-1:0]    last;
  logic [MAXW-1:0] ext;
  logic            lost;

  assign last = prd[NUM_STAGE-1];
  assign ext  = PSGN ?
    {{(MAXW-P){last[P-1]}}, last} :
    {{(MAXW-P){1'b0}}, last};
  assign lost = !fits(ext, DW, PSGN);

  assign out_valid = vld[NUM_STAGE-1];
  assign ovf       = lost;

`ifdef CASE_MUL_PIPE_SAT_EN
  logic [DW-1:0] sat_v;

  always_comb begin
    sat_v = '1;
    if (PSGN) begin
      if (ext[MAXW-1])
        sat_v = {1'b1, {(DW-1){1'b0}}};
      else
        sat_v = {1'b0, {(DW-1){1'b1}}};
    end
  end

  assign dout = lost ? sat_v : ext[DW-1:0];
`else
  assign dout = ext[DW-1:0];
`endif

endmodule

// File: tb/tb_case_mul_pipe_hs.sv
// tb_case_mul_pipe_hs: scoreboard bench for a default instance and a
// single-stage unsigned 16-bit-result instance.
`ifdef CASE_MUL_PIPE_SAT_EN
`define W_OR_S(w, s) (s)
`else
`define W_OR_S(w, s) (w)
`endif

module tb_case_mul_pipe_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv1, ir1, ov1, or1, ovf1;
  logic [9:0] a1;
  logic [5:0] b1;
  logic [9:0] d1;

  logic        iv2, ir2, ov2, or2, ovf2;
  logic [9:0]  a2;
  logic [5:0]  b2;
  logic [15:0] d2;

  case_mul_pipe_hs u_def (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .in_valid (iv1),
    .in_ready (ir1),
    .din0     (a1),
    .din1     (b1),
    .out_valid(ov1),
    .out_ready(or1),
    .dout     (d1),
    .ovf      (ovf1)
  );

  case_mul_pipe_hs #(
    .ID         (2),
    .NUM_STAGE  (1),
    .din0_WIDTH (10),
    .din1_WIDTH (6),
    .dout_WIDTH (16),
    .din0_SIGNED(0),
    .din1_SIGNED(0)
  ) u_uns (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .in_valid (iv2),
    .in_ready (ir2),
    .din0     (a2),
    .din1     (b2),
    .out_valid(ov2),
    .out_ready(or2),
    .dout     (d2),
    .ovf      (ovf2)
  );

  typedef struct {
    logic [15:0] d;
    logic        o;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic exp_t model1(input int a, input int b);
    int          p;
    logic [31:0] pv;
    exp_t        e;
    p   = a * b;
    pv  = p;
    e.o = (p > 511) || (p < -512);
    e.d = {6'b0, pv[9:0]};
`ifdef CASE_MUL_PIPE_SAT_EN
    if (e.o)
      e.d = (p > 0) ? 16'h01FF : 16'h0200;
`endif
    return e;
  endfunction

  function automatic exp_t model2(input logic [9:0] a, input logic [5:0] b);
    int          x, y;
    logic [31:0] pv;
    exp_t        e;
    x   = int'(a);
    y   = int'(b);
    pv  = x * y;
    e.d = pv[15:0];
    e.o = 1'b0;
    return e;
  endfunction

  // monitor for the default instance, including stall stability
  exp_t        e1;
  logic        stall1 = 1'b0;
  logic [9:0]  hold_d;
  logic        hold_o;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall1 = 1'b0;
    end else begin
      if (stall1) begin
        check("stall_valid", ov1, 1);
        check("stall_dout", d1, hold_d);
        check("stall_ovf", ovf1, hold_o);
      end
      if (ov1 && or1) begin
        if (q1.size() == 0) begin
          check("stray1_valid", ov1, 0);
        end else begin
          e1 = q1.pop_front();
          check("dout1", d1, e1.d[9:0]);
          check("ovf1", ovf1, e1.o);
        end
      end
      stall1 = ov1 && !or1;
      hold_d = d1;
      hold_o = ovf1;
    end
  end

  exp_t e2;

  always @(negedge clk) begin
    if (rst_n && ov2 && or2) begin
      if (q2.size() == 0) begin
        check("stray2_valid", ov2, 0);
      end else begin
        e2 = q2.pop_front();
        check("dout2", d2, e2.d);
        check("ovf2", ovf2, e2.o);
      end
    end
  end

  // callers enter just after a rising edge
  task automatic send1(input logic [9:0] a, input logic [5:0] b,
                       input exp_t e);
    int n;
    a1  = a;
    b1  = b;
    iv1 = 1'b1;
    n   = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ir1 && n < 60);
    if (!ir1)
      check("send1_timeout", ir1, 1);
    else
      q1.push_back(e);
    @(posedge clk);
    #1;
    iv1 = 1'b0;
  endtask

  task automatic send2(input logic [9:0] a, input logic [5:0] b,
                       input exp_t e);
    int n;
    a2  = a;
    b2  = b;
    iv2 = 1'b1;
    n   = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ir2 && n < 60);
    if (!ir2)
      check("send2_timeout", ir2, 1);
    else
      q2.push_back(e);
    @(posedge clk);
    #1;
    iv2 = 1'b0;
  endtask

  task automatic lat1(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov1 && n < 20);
    check(name, n, 3);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int which);
    int n;
    n = 0;
    while ((which == 1 ? q1.size() : q2.size()) > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (which == 1)
      check("drain1", q1.size(), 0);
    else
      check("drain2", q2.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   acc;
    int   nthru;
    exp_t e;

    rst_n = 1'b0;
    iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0;
    iv2 = 1'b0; or2 = 1'b1; a2 = '0; b2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid1", ov1, 0);
    check("rst_dout1", d1, 0);
    check("rst_ovf1", ovf1, 0);
    check("rst_out_valid2", ov2, 0);
    check("rst_dout2", d2, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", ir1, 1);
    @(posedge clk);
    #1;

    // 37 * -5 with latency
    send1(10'd37, 6'h3B, '{16'h0347, 1'b0});
    lat1("latency1");

    // corner products, back-to-back
    send1(10'h200, 6'h20, '{`W_OR_S(16'h0000, 16'h01FF), 1'b1});
    send1(10'h1FF, 6'h1F, '{`W_OR_S(16'h01E1, 16'h01FF), 1'b1});
    send1(10'h1FF, 6'h20, '{`W_OR_S(16'h0020, 16'h0200), 1'b1});
    send1(10'h3FF, 6'h3F, '{16'h0001, 1'b0});
    send1(10'h010, 6'h20, '{16'h0200, 1'b0});
    send1(10'h3F0, 6'h20, '{`W_OR_S(16'h0200, 16'h01FF), 1'b1});
    send1(10'h010, 6'h1F, '{16'h01F0, 1'b0});
    send1(10'h011, 6'h1F, '{`W_OR_S(16'h020F, 16'h01FF), 1'b1});
    drain(1);

    // stream with consumer stall
    or1 = 1'b0;
    for (int i = 1; i <= 3; i++)
      send1(10'(i), 6'(i + 1), model1(i, i + 1));
    @(negedge clk);
    check("full_in_ready", ir1, 0);
    @(posedge clk);
    #1;
    fork
      begin
        repeat (4) @(posedge clk);
        #1;
        or1 = 1'b1;
      end
      begin
        for (int i = 4; i <= 8; i++)
          send1(10'(i), 6'(i + 1), model1(i, i + 1));
      end
    join
    drain(1);

    // reset with three products in flight
    or1 = 1'b0;
    send1(10'd5, 6'd3, model1(5, 3));
    send1(10'd6, 6'd3, model1(6, 3));
    send1(10'd7, 6'd3, model1(7, 3));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", ov1, 0);
    check("rst_mid_dout", d1, 0);
    q1.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    or1 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send1(10'd37, 6'h3B, '{16'h0347, 1'b0});
    lat1("latency_after_rst");
    drain(1);

    // unsigned 16-bit result, single stage
    send2(10'h3FF, 6'h3F, '{16'hFBC1, 1'b0});
    send2(10'h3FF, 6'h01, '{16'h03FF, 1'b0});
    send2(10'd5, 6'd7, '{16'h0023, 1'b0});
    drain(2);

    // random valid/ready
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      acc = int'(iv2 && ir2);
      if (acc != 0)
        q2.push_back(model2(a2, b2));
      @(posedge clk);
      #1;
      if (!iv2 || acc != 0) begin
        iv2 = 1'($urandom_range(0, 1));
        a2  = 10'($urandom);
        b2  = 6'($urandom);
      end
      or2 = 1'($urandom_range(0, 1));
    end
    iv2 = 1'b0;
    or2 = 1'b1;
    drain(2);

    // full throughput with both sides high
    nthru = 0;
    iv2 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      a2 = 10'($urandom);
      b2 = 6'($urandom);
      @(negedge clk);
      if (iv2 && ir2) begin
        nthru++;
        e = model2(a2, b2);
        q2.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    iv2 = 1'b0;
    check("throughput2", nthru, 20);
    drain(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
